// File: rtl/csr_regfile_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// csr_if : CSR read/write channel between the CSR functional unit and regfile
// Rev 1.0
// ---------------------------------------------------------------------------
interface csr_if #(
   parameter int XLEN = 64
);
   logic            rvalid;
   logic [11:0]     raddr;
   logic [XLEN-1:0] rdata;
   logic            wvalid;
   logic [11:0]     waddr;
   logic [XLEN-1:0] wdata;

   modport responder (input rvalid, raddr, wvalid, waddr, wdata, output rdata);
   modport requester (output rvalid, raddr, wvalid, waddr, wdata, input rdata);
endinterface
`default_nettype wire

// File: rtl/csr_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// csr_regfile : machine-mode CSRs, counters, trap capture and interrupt state
// Rev 1.0
// ---------------------------------------------------------------------------
module csr_regfile #(
   parameter int                 XLEN        = 64,
   parameter int                 RETIRE_W    = 2,
   parameter int unsigned        HART_ID     = 0,
   parameter logic [XLEN-1:0]    MISA_VAL    = 64'h8000_0000_0014_1100,
   parameter logic [XLEN-1:0]    MTVEC_RESET = 64'h8000_0000
) (
   input  logic                clk,
   input  logic                rst,
   csr_if.responder            csr_io,
   output logic                unmapped_o,
   input  logic [RETIRE_W-1:0] retire_cnt_i,
   input  logic [2:0]          irq_i,
   input  logic                trap_i_valid,
   input  logic [XLEN-1:0]     trap_cause_i,
   input  logic [XLEN-1:0]     trap_pc_i,
   input  logic [XLEN-1:0]     trap_tval_i,
   input  logic                mret_i,
   output logic [XLEN-1:0]     mtvec_o,
   output logic [XLEN-1:0]     mepc_o,
   output logic                mstatus_mie_o,
   output logic                irq_pending_o
);
   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MISA     = 12'h301;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MTVAL    = 12'h343;
   localparam logic [11:0] A_MIP      = 12'h344;
   localparam logic [11:0] A_MCYCLE   = 12'hB00;
   localparam logic [11:0] A_MINSTRET = 12'hB02;
   localparam logic [11:0] A_CYCLE    = 12'hC00;
   localparam logic [11:0] A_INSTRET  = 12'hC02;
   localparam logic [11:0] A_MVENDOR  = 12'hF11;
   localparam logic [11:0] A_MARCHID  = 12'hF12;
   localparam logic [11:0] A_MIMPID   = 12'hF13;
   localparam logic [11:0] A_MHARTID  = 12'hF14;

   logic            mstatus_mie_q, mstatus_mie_d;
   logic            mstatus_mpie_q, mstatus_mpie_d;
   logic [2:0]      mie_q, mie_d;          // {MEIE, MTIE, MSIE}
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic [XLEN-1:0] mscratch_q, mscratch_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d;
   logic [XLEN-1:0] mtval_q, mtval_d;
   logic [63:0]     mcycle_q, mcycle_d;
   logic [63:0]     minstret_q, minstret_d;

   logic [XLEN-1:0] mstatus_val, mie_val, mip_val, rdata_val;
   logic            unmapped_val, wr_en;

   always_comb begin
      mstatus_val        = '0;
      mstatus_val[12:11] = 2'b11;
      mstatus_val[7]     = mstatus_mpie_q;
      mstatus_val[3]     = mstatus_mie_q;
      mie_val            = '0;
      mie_val[3]         = mie_q[0];
      mie_val[7]         = mie_q[1];
      mie_val[11]        = mie_q[2];
      mip_val            = '0;
      mip_val[3]         = irq_i[0];
      mip_val[7]         = irq_i[1];
      mip_val[11]        = irq_i[2];
   end

   always_comb begin
      rdata_val    = '0;
      unmapped_val = 1'b0;
      if (csr_io.rvalid) begin
         case (csr_io.raddr)
            A_MSTATUS:               rdata_val = mstatus_val;
            A_MISA:                  rdata_val = MISA_VAL;
            A_MIE:                   rdata_val = mie_val;
            A_MTVEC:                 rdata_val = mtvec_q;
            A_MSCRATCH:              rdata_val = mscratch_q;
            A_MEPC:                  rdata_val = mepc_q;
            A_MCAUSE:                rdata_val = mcause_q;
            A_MTVAL:                 rdata_val = mtval_q;
            A_MIP:                   rdata_val = mip_val;
            A_MCYCLE, A_CYCLE:       rdata_val = XLEN'(mcycle_q);
            A_MINSTRET, A_INSTRET:   rdata_val = XLEN'(minstret_q);
            A_MVENDOR, A_MARCHID,
            A_MIMPID:                rdata_val = '0;
            A_MHARTID:               rdata_val = XLEN'(HART_ID);
            default:                 unmapped_val = 1'b1;
         endcase
      end
   end

   assign csr_io.rdata = rdata_val;
   assign unmapped_o   = unmapped_val;

   // Read-only space (addr[11:10]==2'b11) never accepts writes.
   assign wr_en = csr_io.wvalid && (csr_io.waddr[11:10] != 2'b11);

   always_comb begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mie_d          = mie_q;
      mtvec_d        = mtvec_q;
      mscratch_d     = mscratch_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      mtval_d        = mtval_q;
      mcycle_d       = mcycle_q + 64'd1;
      minstret_d     = minstret_q + 64'(retire_cnt_i);

      if (wr_en) begin
         case (csr_io.waddr)
            A_MSTATUS: begin
               mstatus_mie_d  = csr_io.wdata[3];
               mstatus_mpie_d = csr_io.wdata[7];
            end
            A_MIE:      mie_d      = {csr_io.wdata[11], csr_io.wdata[7], csr_io.wdata[3]};
            A_MTVEC:    mtvec_d    = {csr_io.wdata[XLEN-1:2], 2'b00};
            A_MSCRATCH: mscratch_d = csr_io.wdata;
            A_MEPC:     mepc_d     = {csr_io.wdata[XLEN-1:2], 2'b00};
            A_MCAUSE:   mcause_d   = csr_io.wdata;
            A_MTVAL:    mtval_d    = csr_io.wdata;
            A_MCYCLE:   mcycle_d   = 64'(csr_io.wdata);
            A_MINSTRET: minstret_d = 64'(csr_io.wdata);
            default: ;
         endcase
      end

      // Trap, then MRET, override any same-cycle CSR write to the registers they own.
      if (trap_i_valid) begin
         mepc_d         = {trap_pc_i[XLEN-1:2], 2'b00};
         mcause_d       = trap_cause_i;
         mtval_d        = trap_tval_i;
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
      end else if (mret_i) begin
         mstatus_mie_d  = mstatus_mpie_q;
         mstatus_mpie_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_q          <= '0;
         mtvec_q        <= MTVEC_RESET;
         mscratch_q     <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mtval_q        <= '0;
         mcycle_q       <= '0;
         minstret_q     <= '0;
      end else begin
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mie_q          <= mie_d;
         mtvec_q        <= mtvec_d;
         mscratch_q     <= mscratch_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         mtval_q        <= mtval_d;
         mcycle_q       <= mcycle_d;
         minstret_q     <= minstret_d;
      end
   end

   assign mtvec_o       = mtvec_q;
   assign mepc_o        = mepc_q;
   assign mstatus_mie_o = mstatus_mie_q;
   assign irq_pending_o = mstatus_mie_q && |(irq_i & mie_q);
endmodule
`default_nettype wire
